// File: rtl/infra_mem_1r1w_bank_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : infra_mem_resp_pkg
// Purpose  : Shared types and helpers for the 1R1W bank responder:
//            responder state encoding, bit-masked write merge and the
//            largest supported read latency.
// Revision : 1.0 - initial release
// ============================================================================
package infra_mem_resp_pkg;

    // Deepest read-return pipe the responder is built for.
    localparam int c_MAX_SRAM_DELAY = 8;

    typedef enum logic [0:0] {
        INIT  = 1'b0,   // zero-fill sweep in progress
        READY = 1'b1    // normal command service
    } state_t;

    // Single-bit form of (old & ~bw) | (din & bw). It is applied across the
    // row with a generate loop, so it works for any row width.
    function automatic logic bw_merge(input logic oldBit, input logic dinBit, input logic bwBit);
        return bwBit ? dinBit : oldBit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/infra_mem_1r1w_bank_resp_delay_pipe.sv
`default_nettype none
// ============================================================================
// Module   : infra_delay_pipe
// Purpose  : Fixed-depth shift register carrying a valid bit alongside a data
//            word. Only the valids are cleared; the data stages are
//            don't-care whenever their valid is low.
// Ports    : clk     - clock
//            rst     - synchronous active-low clear of all valid stages
//            i_vld   - valid entering stage 0
//            i_data  - data entering stage 0
//            o_vld   - valid leaving the last stage
//            o_data  - data leaving the last stage
// Revision : 1.0 - initial release
// ============================================================================
module infra_delay_pipe #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_vld,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_vld,
    output logic [WIDTH-1:0] o_data
);

    logic             r_vld  [DEPTH];
    logic [WIDTH-1:0] r_data [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_vld[i] <= 1'b0;
            end
        end else begin
            r_vld[0] <= i_vld;
            for (int i = 1; i < DEPTH; i++) begin
                r_vld[i] <= r_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        r_data[0] <= i_data;
        for (int i = 1; i < DEPTH; i++) begin
            r_data[i] <= r_data[i-1];
        end
    end

    assign o_vld  = r_vld[DEPTH-1];
    assign o_data = r_data[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/infra_mem_1r1w_bank_resp.sv
`default_nettype none
// ============================================================================
// Module   : infra_mem_1r1w_bank_resp
// Purpose  : Cycle-accurate model of one physical 1R1W memory bank on the
//            t1_* bank interface. Applies bit-masked writes, returns read
//            data SRAM_DELAY cycles after the read command and zero-fills the
//            array after every reset.
// Ports    : clk        - clock
//            rst        - synchronous active-low reset
//            t1_writeA  - write command       t1_addrA - write row
//            t1_bwA     - per-bit write enable t1_dinA - write data
//            t1_readB   - read command        t1_addrB - read row
//            t1_doutB   - read data, held until the next return
//            t1_vldB    - one-cycle pulse marking a new t1_doutB
//            init_busy  - zero-fill in progress
//            acc_err    - sticky: command during fill or row >= NUMSROW
// Revision : 1.0 - initial release
// ============================================================================
module infra_mem_1r1w_bank_resp
    import infra_mem_resp_pkg::*;
#(
    parameter int WIDTH      = 128,
    parameter int NUMSROW    = 256,
    parameter int BITSROW    = 8,
    parameter int SRAM_DELAY = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               t1_writeA,
    input  logic [BITSROW-1:0] t1_addrA,
    input  logic [WIDTH-1:0]   t1_bwA,
    input  logic [WIDTH-1:0]   t1_dinA,
    input  logic               t1_readB,
    input  logic [BITSROW-1:0] t1_addrB,
    output logic [WIDTH-1:0]   t1_doutB,
    output logic               t1_vldB,
    output logic               init_busy,
    output logic               acc_err
);

    // One extra bit so NUMSROW == 2**BITSROW is still representable.
    localparam logic [BITSROW:0]   c_NUMSROW  = (BITSROW+1)'(NUMSROW);
    localparam logic [BITSROW-1:0] c_LAST_ROW = BITSROW'(NUMSROW - 1);
    // Array index width; address bits above it are only used by the range check.
    localparam int                 c_IDXW     = (NUMSROW > 1) ? $clog2(NUMSROW) : 1;

    generate
        if (SRAM_DELAY < 1 || SRAM_DELAY > c_MAX_SRAM_DELAY) begin : g_bad_delay
            $error("infra_mem_1r1w_bank_resp: SRAM_DELAY out of range");
        end
    endgenerate

    state_t               r_state;
    state_t               w_nextState;
    logic [BITSROW-1:0]   r_initRow;
    logic [WIDTH-1:0]     r_mem [0:NUMSROW-1];

    logic                 w_inRangeA;
    logic                 w_inRangeB;
    logic [c_IDXW-1:0]    w_idxA;
    logic [c_IDXW-1:0]    w_idxB;
    logic [WIDTH-1:0]     w_rowA;
    logic [WIDTH-1:0]     w_mergeA;
    logic [WIDTH-1:0]     w_rdData;

    logic                 w_memWe;
    logic [c_IDXW-1:0]    w_memIdx;
    logic [WIDTH-1:0]     w_memData;
    logic                 w_pipeVld;
    logic                 w_errEvent;
    logic                 w_pipeOutVld;
    logic [WIDTH-1:0]     w_pipeOutData;

    logic [WIDTH-1:0]     r_doutB;
    logic                 r_vldB;
    logic                 r_accErr;

    assign w_inRangeA = ({1'b0, t1_addrA} < c_NUMSROW);
    assign w_inRangeB = ({1'b0, t1_addrB} < c_NUMSROW);
    assign w_idxA     = t1_addrA[c_IDXW-1:0];
    assign w_idxB     = t1_addrB[c_IDXW-1:0];

    // Out-of-range rows never touch the array; reads of them return zero.
    assign w_rowA   = w_inRangeA ? r_mem[w_idxA] : '0;
    assign w_rdData = w_inRangeB ? r_mem[w_idxB] : '0;

    generate
        for (genvar g = 0; g < WIDTH; g++) begin : g_merge
            assign w_mergeA[g] = bw_merge(w_rowA[g], t1_dinA[g], t1_bwA[g]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= INIT;
            r_initRow <= '0;
        end else begin
            r_state <= w_nextState;
            if (r_state == INIT) begin
                r_initRow <= r_initRow + 1'b1;
            end
        end
    end

    // The array write port is shared between the fill sweep and user writes.
    // Writes are masked while rst is low so reset alone never alters the
    // array; only the following fill does.
    always_comb begin
        w_nextState = r_state;
        w_memWe     = 1'b0;
        w_memIdx    = r_initRow[c_IDXW-1:0];
        w_memData   = '0;
        w_pipeVld   = 1'b0;
        w_errEvent  = 1'b0;
        case (r_state)
            INIT: begin
                w_memWe    = rst;
                w_memIdx   = r_initRow[c_IDXW-1:0];
                w_memData  = '0;
                w_errEvent = t1_writeA | t1_readB;
                if (r_initRow == c_LAST_ROW) begin
                    w_nextState = READY;
                end
            end
            READY: begin
                w_memWe    = rst & t1_writeA & w_inRangeA;
                w_memIdx   = w_idxA;
                w_memData  = w_mergeA;
                // Out-of-range reads still occupy a slot and return zero.
                w_pipeVld  = t1_readB;
                w_errEvent = (t1_writeA & ~w_inRangeA) | (t1_readB & ~w_inRangeB);
            end
            default: begin
                w_nextState = INIT;
            end
        endcase
    end

    // The read port samples the array before this edge's write lands, giving
    // read-before-write for a same-cycle collision.
    always_ff @(posedge clk) begin
        if (w_memWe) begin
            r_mem[w_memIdx] <= w_memData;
        end
    end

    infra_delay_pipe #(
        .DEPTH (SRAM_DELAY),
        .WIDTH (WIDTH)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .i_vld  (w_pipeVld),
        .i_data (w_rdData),
        .o_vld  (w_pipeOutVld),
        .o_data (w_pipeOutData)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_doutB  <= '0;
            r_vldB   <= 1'b0;
            r_accErr <= 1'b0;
        end else begin
            r_vldB <= w_pipeOutVld;
            if (w_pipeOutVld) begin
                r_doutB <= w_pipeOutData;
            end
            if (w_errEvent) begin
                r_accErr <= 1'b1;
            end
        end
    end

    assign t1_doutB  = r_doutB;
    assign t1_vldB   = r_vldB;
    assign init_busy = (r_state == INIT);
    assign acc_err   = r_accErr;

endmodule
`default_nettype wire

// File: tb/tb_infra_mem_1r1w_bank_resp.sv
`default_nettype none
// ============================================================================
// Module   : tb_infra_mem_1r1w_bank_resp
// Purpose  : Directed self-checking bench for the 1R1W bank responder.
//            Three instances: A (defaults), B (NUMSROW=200), C (SRAM_DELAY=4,
//            16 rows). Shared command bus, steered to one instance by sel.
// Revision : 1.0 - initial release
// ============================================================================
module tb_infra_mem_1r1w_bank_resp;

    localparam int W = 128;

    logic         clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]   rstN;
    logic [1:0]   sel;
    logic         wr, rd;
    logic [7:0]   waddr, raddr;
    logic [W-1:0] bw, din;

    logic [W-1:0] doutA, doutB, doutC;
    logic         vldA, vldB, vldC, busyA, busyB, busyC, errA, errB, errC;
    logic [W-1:0] oDout;
    logic         oVld, oBusy, oErr;

    int nTests = 0;
    int nFail  = 0;

    infra_mem_1r1w_bank_resp #(.WIDTH(W), .NUMSROW(256), .BITSROW(8), .SRAM_DELAY(2)) u_dutA (
        .clk(clk), .rst(rstN[0]),
        .t1_writeA(wr && (sel == 2'd0)), .t1_addrA(waddr), .t1_bwA(bw), .t1_dinA(din),
        .t1_readB(rd && (sel == 2'd0)), .t1_addrB(raddr), .t1_doutB(doutA), .t1_vldB(vldA),
        .init_busy(busyA), .acc_err(errA));

    infra_mem_1r1w_bank_resp #(.WIDTH(W), .NUMSROW(200), .BITSROW(8), .SRAM_DELAY(2)) u_dutB (
        .clk(clk), .rst(rstN[1]),
        .t1_writeA(wr && (sel == 2'd1)), .t1_addrA(waddr), .t1_bwA(bw), .t1_dinA(din),
        .t1_readB(rd && (sel == 2'd1)), .t1_addrB(raddr), .t1_doutB(doutB), .t1_vldB(vldB),
        .init_busy(busyB), .acc_err(errB));

    infra_mem_1r1w_bank_resp #(.WIDTH(W), .NUMSROW(16), .BITSROW(4), .SRAM_DELAY(4)) u_dutC (
        .clk(clk), .rst(rstN[2]),
        .t1_writeA(wr && (sel == 2'd2)), .t1_addrA(waddr[3:0]), .t1_bwA(bw), .t1_dinA(din),
        .t1_readB(rd && (sel == 2'd2)), .t1_addrB(raddr[3:0]), .t1_doutB(doutC), .t1_vldB(vldC),
        .init_busy(busyC), .acc_err(errC));

    always_comb begin
        oDout = doutA; oVld = vldA; oBusy = busyA; oErr = errA;
        case (sel)
            2'd1:    begin oDout = doutB; oVld = vldB; oBusy = busyB; oErr = errB; end
            2'd2:    begin oDout = doutC; oVld = vldC; oBusy = busyC; oErr = errC; end
            default: begin oDout = doutA; oVld = vldA; oBusy = busyA; oErr = errA; end
        endcase
    end

    function automatic logic [W-1:0] patC(input int i);
        logic [31:0] x;
        x = 32'(i);
        return {32'hC0DE_0000 | x, 32'h5A5A_5A5A, ~x, x};
    endfunction

    // Drives one write for a single edge.
    task automatic do_write(input logic [7:0] a, input logic [W-1:0] m, input logic [W-1:0] d);
        @(negedge clk); wr = 1'b1; waddr = a; bw = m; din = d;
        @(negedge clk); wr = 1'b0;
    endtask

    // Issues one read and reports whether valid showed early and whether it
    // showed exactly dly edges after the command edge.
    task automatic do_read(input logic [7:0] a, input int dly, output logic early,
                           output logic on, output logic [W-1:0] data);
        early = 1'b0;
        @(negedge clk); rd = 1'b1; raddr = a;
        @(negedge clk); rd = 1'b0;
        for (int k = 1; k < dly; k++) begin
            @(negedge clk);
            if (oVld) early = 1'b1;
        end
        @(negedge clk); on = oVld; data = oDout;
    endtask

    task automatic test_reset();
        int cnt;
        logic b199, b200;
        sel = 2'd0; wr = 1'b0; rd = 1'b0; waddr = '0; raddr = '0; bw = '0; din = '0;
        rstN = 3'b000;
        repeat (3) @(negedge clk);
        nTests++; if (doutA !== '0)  begin nFail++; $display("FAIL reset_dout got %h want 0", doutA); end
        nTests++; if (vldA !== 1'b0) begin nFail++; $display("FAIL reset_vld got %b want 0", vldA); end
        nTests++; if (busyA !== 1'b1) begin nFail++; $display("FAIL reset_busy got %b want 1", busyA); end
        nTests++; if (errA !== 1'b0) begin nFail++; $display("FAIL reset_err got %b want 0", errA); end
        rstN = 3'b111;
        cnt = 0; b199 = 1'bx; b200 = 1'bx;
        while (busyA === 1'b1 && cnt < 400) begin
            @(negedge clk); cnt++;
            if (cnt == 199) b199 = busyB;
            if (cnt == 200) b200 = busyB;
        end
        nTests++; if (cnt != 256) begin nFail++; $display("FAIL init_len_256 got %0d want 256", cnt); end
        nTests++; if (b199 !== 1'b1) begin nFail++; $display("FAIL init_len_200_hi got %b want 1", b199); end
        nTests++; if (b200 !== 1'b0) begin nFail++; $display("FAIL init_len_200_lo got %b want 0", b200); end
    endtask

    task automatic test_init_read();
        logic e, o; logic [W-1:0] d;
        sel = 2'd0;
        do_read(8'd17, 2, e, o, d);
        nTests++; if (e !== 1'b0) begin nFail++; $display("FAIL rd17_early got %b want 0", e); end
        nTests++; if (o !== 1'b1) begin nFail++; $display("FAIL rd17_vld got %b want 1", o); end
        nTests++; if (d !== '0)   begin nFail++; $display("FAIL rd17_data got %h want 0", d); end
        nTests++; if (errA !== 1'b0) begin nFail++; $display("FAIL rd17_err got %b want 0", errA); end
    endtask

    task automatic test_bw_write();
        logic e, o; logic [W-1:0] d;
        sel = 2'd0;
        @(negedge clk); wr = 1'b1; waddr = 8'd5; bw = 128'hFF; din = '1;
        @(negedge clk); wr = 1'b0; rd = 1'b1; raddr = 8'd5;
        @(negedge clk); rd = 1'b0;
        @(negedge clk); e = vldA;
        @(negedge clk);
        nTests++; if (e !== 1'b0) begin nFail++; $display("FAIL bw_early got %b want 0", e); end
        nTests++; if (vldA !== 1'b1 || doutA !== 128'hFF)
            begin nFail++; $display("FAIL bw_low_byte got vld=%b %h want vld=1 %h", vldA, doutA, 128'hFF); end
        do_write(8'd5, '0, '0);
        do_read(8'd5, 2, e, o, d);
        nTests++; if (o !== 1'b1 || d !== 128'hFF)
            begin nFail++; $display("FAIL bw_zero got vld=%b %h want vld=1 %h", o, d, 128'hFF); end
        do_write(8'd5, {32'hFFFF_FFFF, 96'h0}, {32'hDEAD_BEEF, {96{1'b1}}});
        do_read(8'd5, 2, e, o, d);
        nTests++; if (o !== 1'b1 || d !== {32'hDEAD_BEEF, 88'h0, 8'hFF})
            begin nFail++; $display("FAIL bw_high_word got vld=%b %h want vld=1 %h", o, d, {32'hDEAD_BEEF, 88'h0, 8'hFF}); end
    endtask

    task automatic test_rbw();
        sel = 2'd0;
        @(negedge clk); wr = 1'b1; waddr = 8'd9; din = {16{8'hA5}}; bw = '1; rd = 1'b1; raddr = 8'd9;
        @(negedge clk); wr = 1'b0; rd = 1'b1; raddr = 8'd9;
        @(negedge clk); rd = 1'b0;
        nTests++; if (vldA !== 1'b0) begin nFail++; $display("FAIL rbw_early got %b want 0", vldA); end
        @(negedge clk);
        nTests++; if (vldA !== 1'b1 || doutA !== '0)
            begin nFail++; $display("FAIL rbw_old got vld=%b %h want vld=1 0", vldA, doutA); end
        @(negedge clk);
        nTests++; if (vldA !== 1'b1 || doutA !== {16{8'hA5}})
            begin nFail++; $display("FAIL rbw_new got vld=%b %h want vld=1 %h", vldA, doutA, {16{8'hA5}}); end
        @(negedge clk);
        nTests++; if (vldA !== 1'b0 || doutA !== {16{8'hA5}})
            begin nFail++; $display("FAIL rbw_hold got vld=%b %h want vld=0 %h", vldA, doutA, {16{8'hA5}}); end
    endtask

    task automatic test_out_of_range();
        logic e, o; logic [W-1:0] d;
        logic [7:0] rows [4];
        logic [W-1:0] exp [4];
        sel = 2'd1;
        nTests++; if (errB !== 1'b0) begin nFail++; $display("FAIL oob_err_clean got %b want 0", errB); end
        do_write(8'd3, '1, 128'h1234_5678);
        do_read(8'd3, 2, e, o, d);
        nTests++; if (o !== 1'b1 || d !== 128'h1234_5678)
            begin nFail++; $display("FAIL oob_row3 got vld=%b %h want vld=1 %h", o, d, 128'h1234_5678); end
        do_read(8'd250, 2, e, o, d);
        nTests++; if (e !== 1'b0 || o !== 1'b1 || d !== '0)
            begin nFail++; $display("FAIL oob_read got early=%b vld=%b %h want 0 1 0", e, o, d); end
        nTests++; if (errB !== 1'b1) begin nFail++; $display("FAIL oob_read_err got %b want 1", errB); end
        do_write(8'd250, '1, '1);
        rows[0] = 8'd3;  exp[0] = 128'h1234_5678;
        rows[1] = 8'd50; exp[1] = '0;
        rows[2] = 8'd122; exp[2] = '0;
        rows[3] = 8'd199; exp[3] = '0;
        for (int i = 0; i < 4; i++) begin
            do_read(rows[i], 2, e, o, d);
            nTests++; if (o !== 1'b1 || d !== exp[i])
                begin nFail++; $display("FAIL oob_write_row%0d got vld=%b %h want vld=1 %h", rows[i], o, d, exp[i]); end
        end
    endtask

    task automatic test_reset_during_ops();
        int vc, cnt;
        logic e, o; logic [W-1:0] d;
        sel = 2'd0;
        // Read in flight when rst drops must never return.
        @(negedge clk); rd = 1'b1; raddr = 8'd9;
        @(negedge clk); rd = 1'b0; rstN[0] = 1'b0;
        vc = 0;
        repeat (4) begin @(negedge clk); if (vldA) vc++; end
        nTests++; if (vc != 0) begin nFail++; $display("FAIL inflight_vld got %0d pulses want 0", vc); end
        nTests++; if (doutA !== '0) begin nFail++; $display("FAIL inflight_dout got %h want 0", doutA); end
        rstN[0] = 1'b1;
        repeat (10) @(negedge clk);
        wr = 1'b1; waddr = 8'd3; bw = '1; din = '1; rd = 1'b1; raddr = 8'd3;
        @(negedge clk); wr = 1'b0; rd = 1'b0;
        vc = 0;
        repeat (4) begin @(negedge clk); if (vldA) vc++; end
        nTests++; if (vc != 0) begin nFail++; $display("FAIL init_cmd_vld got %0d pulses want 0", vc); end
        nTests++; if (errA !== 1'b1) begin nFail++; $display("FAIL init_cmd_err got %b want 1", errA); end
        repeat (85) @(negedge clk);
        rstN[0] = 1'b0;
        @(negedge clk);
        nTests++; if (errA !== 1'b0 || busyA !== 1'b1)
            begin nFail++; $display("FAIL rerst_state got err=%b busy=%b want 0 1", errA, busyA); end
        rstN[0] = 1'b1;
        cnt = 0;
        while (busyA === 1'b1 && cnt < 400) begin @(negedge clk); cnt++; end
        nTests++; if (cnt != 256) begin nFail++; $display("FAIL rerst_len got %0d want 256", cnt); end
        do_read(8'd9, 2, e, o, d);
        nTests++; if (o !== 1'b1 || d !== '0)
            begin nFail++; $display("FAIL refill_row9 got vld=%b %h want vld=1 0", o, d); end
    endtask

    task automatic test_back_to_back();
        int ev, pc;
        logic expV;
        sel = 2'd2;
        for (int i = 0; i < 16; i++) do_write(8'(i), '1, patC(i));
        pc = 0;
        for (int t = 0; t <= 21; t++) begin
            @(negedge clk);
            if (t >= 1) begin
                ev = t - 1;
                expV = (ev >= 4 && ev <= 19);
                if (vldC) pc++;
                nTests++; if (vldC !== expV)
                    begin nFail++; $display("FAIL b2b_vld_e%0d got %b want %b", ev, vldC, expV); end
                if (expV) begin
                    nTests++; if (doutC !== patC(ev - 4))
                        begin nFail++; $display("FAIL b2b_data_e%0d got %h want %h", ev, doutC, patC(ev - 4)); end
                end
            end
            if (t < 16) begin rd = 1'b1; raddr = 8'(t); end
            else rd = 1'b0;
        end
        nTests++; if (pc != 16) begin nFail++; $display("FAIL b2b_count got %0d want 16", pc); end
    endtask

    initial begin
        test_reset();
        test_init_read();
        test_bw_write();
        test_rbw();
        test_out_of_range();
        test_reset_during_ops();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
